// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Function : UART byte-stream boot loader. It takes a 32-bit word count
//            followed by that many words, writes them into instruction memory,
//            sends an 8'hAA acknowledge byte, then releases the CPU reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rom_wren,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [31:0]           rom_write_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  cpu_reset_n,
  output logic                  error
);

  localparam int          IDX_W     = ADDR_WIDTH - 2;
  localparam logic [32:0] MAX_WORDS = 33'd1 << IDX_W;
  localparam logic [7:0]  ACK_BYTE  = 8'hAA;

  localparam logic [2:0] ST_COUNT = 3'd0;
  localparam logic [2:0] ST_DATA  = 3'd1;
  localparam logic [2:0] ST_ACK   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [1:0]       byte_cnt;
  logic [23:0]      byte_buf;
  logic [31:0]      word_count;
  logic [IDX_W-1:0] word_idx;

  logic             accepting;
  logic             word_done;
  logic             last_word;
  logic [31:0]      assembled;

  logic                  rom_wren_next;
  logic [ADDR_WIDTH-1:0] rom_address_next;
  logic [31:0]           rom_write_data_next;
  logic                  tx_valid_next;
  logic [7:0]            tx_data_next;
  logic                  cpu_reset_n_next;
  logic                  error_next;

  assign accepting = rx_valid && ((state == ST_COUNT) || (state == ST_DATA));
  assign word_done = accepting && (byte_cnt == 2'd3);
  // The incoming byte completes the word directly; only three bytes need storing.
  assign assembled = {rx_data, byte_buf};
  assign last_word = ({{(32-IDX_W){1'b0}}, word_idx} == (word_count - 32'd1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_COUNT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_COUNT: begin
        if (word_done) begin
          if (assembled == 32'd0) begin
            state_next = ST_ACK;
          end else if ({1'b0, assembled} > MAX_WORDS) begin
            state_next = ST_ERROR;
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_done && last_word) begin
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        if (tx_ready) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN:   state_next = ST_RUN;
      ST_ERROR: state_next = ST_ERROR;
      default:  state_next = ST_ERROR;
    endcase
  end

  // Byte assembly, word count and word index
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt   <= 2'd0;
      byte_buf   <= 24'd0;
      word_count <= 32'd0;
      word_idx   <= '0;
    end else if (accepting) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    byte_buf[7:0]   <= rx_data;
        2'd1:    byte_buf[15:8]  <= rx_data;
        2'd2:    byte_buf[23:16] <= rx_data;
        default: byte_buf        <= byte_buf;
      endcase
      if (word_done) begin
        if (state == ST_COUNT) begin
          word_count <= assembled;
          word_idx   <= '0;
        end else if (!last_word) begin
          // Held on the last word so a full-capacity load never wraps the index.
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

  // Output next-value logic; outputs follow the state being entered
  always_comb begin
    rom_wren_next       = word_done && (state == ST_DATA);
    rom_address_next    = rom_address;
    rom_write_data_next = rom_write_data;
    if (rom_wren_next) begin
      rom_address_next    = {word_idx, 2'b00};
      rom_write_data_next = assembled;
    end
    tx_valid_next    = (state_next == ST_ACK);
    tx_data_next     = (state_next == ST_ACK) ? ACK_BYTE : tx_data;
    cpu_reset_n_next = (state_next == ST_RUN);
    error_next       = (state_next == ST_ERROR);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_wren       <= 1'b0;
      rom_address    <= '0;
      rom_write_data <= 32'd0;
      tx_valid       <= 1'b0;
      tx_data        <= 8'd0;
      cpu_reset_n    <= 1'b0;
      error          <= 1'b0;
    end else begin
      rom_wren       <= rom_wren_next;
      rom_address    <= rom_address_next;
      rom_write_data <= rom_write_data_next;
      tx_valid       <= tx_valid_next;
      tx_data        <= tx_data_next;
      cpu_reset_n    <= cpu_reset_n_next;
      error          <= error_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Function : Bench for program_loader; drives two instances (ADDR_WIDTH 16 and
//            4) with the same byte stream and compares against a loader model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;

  localparam int M_COUNT = 0;
  localparam int M_DATA  = 1;
  localparam int M_ACK   = 2;
  localparam int M_RUN   = 3;
  localparam int M_ERR   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic tx_ready = 1'b0;

  logic        a_wren, a_txv, a_cpun, a_err;
  logic [15:0] a_addr;
  logic [31:0] a_data;
  logic [7:0]  a_txd;
  logic        b_wren, b_txv, b_cpun, b_err;
  logic [3:0]  b_addr;
  logic [31:0] b_data;
  logic [7:0]  b_txd;

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rom_wren(a_wren), .rom_address(a_addr), .rom_write_data(a_data),
    .tx_valid(a_txv), .tx_data(a_txd), .tx_ready(tx_ready),
    .cpu_reset_n(a_cpun), .error(a_err)
  );

  program_loader #(.ADDR_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rom_wren(b_wren), .rom_address(b_addr), .rom_write_data(b_data),
    .tx_valid(b_txv), .tx_data(b_txd), .tx_ready(tx_ready),
    .cpu_reset_n(b_cpun), .error(b_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit primed = 1'b0;
  bit tr_lvl = 1'b0;

  // Loader model state, one slot per instance
  longint      max_words [2] = '{16384, 4};
  int          m_state   [2];
  int          m_cnt     [2];
  logic [31:0] m_word    [2];
  longint      m_n       [2];
  longint      m_idx     [2];
  bit          chk_all   [2];
  logic        e_wren [2], e_txv [2], e_cpun [2], e_err [2];
  logic [31:0] e_addr [2], e_data [2];
  logic [7:0]  e_txd  [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit rs, input bit rv,
                            input logic [7:0] rd, input bit tr);
    logic [31:0] w;
    if (rs) begin
      m_state[k] = M_COUNT;  m_cnt[k] = 0;  m_word[k] = 0;
      m_n[k] = 0;  m_idx[k] = 0;  chk_all[k] = 1'b1;
      e_wren[k] = 0;  e_addr[k] = 0;  e_data[k] = 0;
      e_txv[k] = 0;  e_txd[k] = 0;  e_cpun[k] = 0;  e_err[k] = 0;
      return;
    end
    chk_all[k] = 1'b0;
    e_wren[k]  = 1'b0;
    if (rv && (m_state[k] == M_COUNT || m_state[k] == M_DATA)) begin
      m_word[k][8*m_cnt[k] +: 8] = rd;
      m_cnt[k]++;
      if (m_cnt[k] == 4) begin
        w = m_word[k];
        m_cnt[k] = 0;
        if (m_state[k] == M_COUNT) begin
          if (w == 0)                          m_state[k] = M_ACK;
          else if (longint'(w) > max_words[k]) m_state[k] = M_ERR;
          else begin
            m_state[k] = M_DATA;  m_n[k] = longint'(w);  m_idx[k] = 0;
          end
        end else begin
          e_wren[k] = 1'b1;
          e_addr[k] = 32'(m_idx[k] * 4);
          e_data[k] = w;
          m_idx[k]++;
          if (m_idx[k] == m_n[k]) m_state[k] = M_ACK;
        end
      end
    end else if (m_state[k] == M_ACK && tr) begin
      m_state[k] = M_RUN;
    end
    e_txv[k]  = (m_state[k] == M_ACK);
    if (m_state[k] == M_ACK) e_txd[k] = 8'hAA;
    e_cpun[k] = (m_state[k] == M_RUN);
    e_err[k]  = (m_state[k] == M_ERR);
  endtask

  task automatic compare_one(input int k, input string nm, input logic wren,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic txv, input logic [7:0] txd,
                             input logic cpun, input logic err);
    check({nm, ".rom_wren"}, 64'(wren), 64'(e_wren[k]));
    check({nm, ".tx_valid"}, 64'(txv), 64'(e_txv[k]));
    check({nm, ".cpu_reset_n"}, 64'(cpun), 64'(e_cpun[k]));
    check({nm, ".error"}, 64'(err), 64'(e_err[k]));
    if (e_wren[k] || chk_all[k]) begin
      check({nm, ".rom_address"}, 64'(addr), 64'(e_addr[k]));
      check({nm, ".rom_write_data"}, 64'(data), 64'(e_data[k]));
    end
    if (e_txv[k] || chk_all[k]) check({nm, ".tx_data"}, 64'(txd), 64'(e_txd[k]));
  endtask

  // One clock: check what the last edge produced, then drive the next edge
  task automatic cycle(input bit rs, input bit rv, input logic [7:0] rd, input bit tr);
    @(negedge clk);
    if (primed) begin
      compare_one(0, "aw16", a_wren, 32'(a_addr), a_data, a_txv, a_txd, a_cpun, a_err);
      compare_one(1, "aw4",  b_wren, 32'(b_addr), b_data, b_txv, b_txd, b_cpun, b_err);
    end
    reset = rs;  rx_valid = rv;  rx_data = rd;  tx_ready = tr;
    model_step(0, rs, rv, rd, tr);
    model_step(1, rs, rv, rd, tr);
    primed = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 8'h00, tr_lvl);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 8'h5A, 1'b1);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    cycle(1'b0, 1'b1, b, tr_lvl);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
  endtask

  initial begin
    tr_lvl = 1'b0;
    do_reset();
    idle(2);

    // Reference two-word program, then acknowledge
    send_word(32'd2, 0);
    send_word(32'h00100513, 0);
    send_word(32'h00200593, 0);
    idle(3);
    tr_lvl = 1'b1;
    idle(3);
    // Bytes injected while running must be ignored
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    idle(2);

    // Zero-length load holds in ACK until tx_ready
    tr_lvl = 1'b0;
    do_reset();
    send_word(32'd0, 1);
    idle(5);
    tr_lvl = 1'b1;
    idle(3);

    // Count 5: overflow on the 4-word instance, legal on the other
    tr_lvl = 1'b0;
    do_reset();
    send_word(32'd5, 0);
    for (int i = 0; i < 5; i++) send_word($urandom, 1);
    idle(2);
    tr_lvl = 1'b1;
    idle(2);

    // Full capacity of the small instance
    tr_lvl = 1'b0;
    do_reset();
    send_word(32'd4, 0);
    for (int i = 0; i < 4; i++) send_word($urandom, 0);
    idle(2);
    tr_lvl = 1'b1;
    idle(2);

    // Overflow of the large instance
    tr_lvl = 1'b0;
    do_reset();
    send_word(32'h0000_4001, 0);
    send_word($urandom, 0);
    idle(3);

    // Reset in the middle of word 1, then a fresh one-word load
    do_reset();
    send_word(32'd3, 0);
    send_word($urandom, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset();
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    idle(2);
    tr_lvl = 1'b1;
    idle(2);

    // Back-to-back three-word load
    tr_lvl = 1'b0;
    do_reset();
    send_word(32'd3, 0);
    for (int i = 0; i < 3; i++) send_word($urandom, 0);
    idle(2);
    tr_lvl = 1'b1;
    idle(2);

    // Randomized loads with gaps, handshake delays and occasional early reset
    for (int it = 0; it < 30; it++) begin
      int n;
      tr_lvl = 1'b0;
      do_reset();
      n = $urandom_range(0, 6);
      send_word(32'(n), 2);
      for (int w = 0; w < n; w++) begin
        if ($urandom_range(0, 9) == 0) begin
          send_byte(8'($urandom), 0);
          do_reset();
          send_word(32'd1, 1);
        end
        send_word($urandom, $urandom_range(0, 2));
      end
      for (int c = 0; c < 6; c++) begin
        tr_lvl = 1'($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 2) == 0) cycle(1'b0, 1'b1, 8'($urandom), tr_lvl);
        else idle(1);
      end
      tr_lvl = 1'b1;
      idle(2);
      send_byte(8'($urandom), 0);
    end

    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
